frame_addr_gen: RTL and testbench
=================================

# frame_addr_gen

Burst address generator for the DMA frame writer, generalising the single-buffer generator to N rotating frame buffers. It counts accepted data beats, emits one base+offset burst address per burst over a valid/ready handshake, and queues up to MAX_PEND outstanding addresses. It also detects end of frame and rotates to the next buffer on frame start, optionally skipping the buffer currently held by the reader. It sits between the pixel packer (beat strobes) and the AXI write-address channel.

## Interface
- ADDR_W, 32, address and offset width
- N_BUF, 4, number of frame buffers (≥2)
- BURST_BEATS, 16, data beats per burst (power of two)
- BURST_BYTES, 128, address increment per burst
- MAX_PEND, 4, maximum queued unaccepted addresses
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst_n  in  1  reset, synchronous, active-low
- buf_base  in  N_BUF*ADDR_W  base address of buffer i at bits [i*ADDR_W +: ADDR_W]; static while running
- frame_bytes  in  ADDR_W  bytes per frame, multiple of BURST_BYTES, nonzero
- frame_start  in  1  single-cycle pulse, start a new frame
- data_valid  in  1  one data beat accepted by the writer this cycle
- rd_lock  in  1  reader holds buffer rd_buf
- rd_buf  in  clog2(N_BUF)  buffer index held by reader
- addr  out  ADDR_W  burst address, valid while addr_valid
- addr_valid  out  1  address request
- addr_ready  in  1  downstream accepts address
- cur_buf  out  clog2(N_BUF)  buffer being written
- frame_done  out  1  one-cycle pulse, frame fully addressed
- done_buf  out  clog2(N_BUF)  buffer of the last completed frame
- overrun  out  1  sticky: beat or burst lost

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset: IDLE, cur_buf=0, done_buf=0, all offsets/counters 0, all outputs 0.
- Two offsets: req_off (next burst to request) and iss_off (next to hand out). pending = (req_off − iss_off)/BURST_BYTES, held as a separate counter 0..MAX_PEND.
- addr = buf_base[cur_buf] + iss_off, modulo 2^ADDR_W; addr_valid = (pending≠0).
- Handshake: addr_valid∧addr_ready → iss_off += BURST_BYTES, pending−1. addr and addr_valid stay stable until accepted; valid never drops without a handshake.
- RUN: beat_cnt counts data_valid modulo BURST_BEATS. A beat with beat_cnt=0 is a burst start:
  - pending<MAX_PEND: req_off += BURST_BYTES, pending+1.
  - pending=MAX_PEND: burst dropped, req_off unchanged, overrun←1.
- Burst start and handshake in the same cycle: pending unchanged, both offsets advance.
- End of frame: burst start with req_off+BURST_BYTES ≥ frame_bytes (compared in ADDR_W+1 bits) → DRAIN. In DRAIN/DONE/IDLE, data_valid is not counted; in DRAIN/DONE it sets overrun.
- DRAIN, pending reaches 0 → DONE, frame_done pulse, done_buf←cur_buf.
- frame_start in IDLE or DONE: next cycle RUN, cur_buf←next buffer, req_off=iss_off=0, beat_cnt=0.
  - From IDLE, next buffer is 0. Otherwise next is (cur_buf+1) mod N_BUF.
- frame_start in RUN/DRAIN (abort): further beats are not counted, and the pulse is latched in start_pend. The restart is applied in the cycle after pending reaches 0; frame_done is not pulsed for the aborted frame.
- Multiple frame_start pulses while latched collapse to one.
- overrun clears only on reset.
- Reset mid-frame: everything returns to reset values immediately. Outstanding addresses are discarded.

## Timing
- Burst-start beat in cycle n → addr_valid=1 in cycle n+1.
- Handshake in cycle n → addr shows the next address, or addr_valid=0, in cycle n+1.
- frame_start in cycle n (IDLE/DONE) → cur_buf updated and state RUN in cycle n+1; a beat in cycle n+1 is counted.
- Last handshake in cycle n → frame_done=1 in cycle n+1 only.
- Combinational path addr_ready → nothing; all outputs are registered or derived from registers.

## Configuration
- FRAME_ADDR_GEN_SKIP_LOCKED_EN defined:
  - Buffer rotation skips index rd_buf when rd_lock=1, taking the following index.
  - With N_BUF≥2, a candidate always exists.
- Undefined: strict round-robin. rd_lock and rd_buf remain as ports and are ignored.

## Structure
- frame_addr_gen_pkg: state enum (IDLE, RUN, DRAIN, DONE) and an idx-width helper function clog2.
- One sub-module, buf_rotator: combinational next-index selection from cur_buf, rd_lock, rd_buf and the from-IDLE flag; the skip logic lives here under the macro.

## Test plan
Common config for all scenarios: N_BUF=3, BURST_BEATS=4, BURST_BYTES=64, MAX_PEND=2, frame_bytes=256, bases 0x1000/0x2000/0x3000.
- Full frame, addr_ready=1: frame_start, then 16 beats → addresses 0x1000, 0x1040, 0x1080, 0x10C0; frame_done one cycle after the last handshake; done_buf=0.
- Backpressure, addr_ready=0: 12 beats → addr_valid held at 0x1000, third burst dropped, overrun=1; after release, 0x1000 then 0x1040 only.
- Rotation: three frames → cur_buf 0, 1, 2, then 0 on the fourth frame_start.
- Skip, macro defined: rd_lock=1, rd_buf=1, frame_start while DONE on buffer 0 → cur_buf=2; macro undefined → cur_buf=1.
- Abort: frame_start after 6 beats with addr_ready=0 → both queued addresses issued after release; restart on buffer 1 with next address 0x2000; no frame_done.
- Reset: sys_rst_n=0 for one cycle mid-frame → next cycle addr_valid=0, cur_buf=0, overrun=0, state IDLE; beats are ignored until frame_start.

Source files
------------

// File: rtl/frame_addr_gen_pkg.sv
// Shared types and helpers for the frame_addr_gen burst address generator.
package frame_addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Ceiling log2, used to size buffer-index, beat and pending counters.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_addr_gen_if.sv
// Burst address request channel between frame_addr_gen and the AXI write-address stage.
interface frame_addr_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;

    modport master (output addr, output addr_valid, input addr_ready);
    modport slave  (input addr, input addr_valid, output addr_ready);
endinterface

// File: rtl/frame_addr_gen_buf_rotator.sv
// Next frame-buffer index selection; FRAME_ADDR_GEN_SKIP_LOCKED_EN skips the reader's locked buffer.
module frame_addr_gen_buf_rotator
    import frame_addr_gen_pkg::*;
#(
    parameter int unsigned N_BUF = 4,
    parameter int unsigned IDX_W = clog2(N_BUF)
) (
    input  logic [IDX_W-1:0] cur_buf,
    input  logic             rd_lock,
    input  logic [IDX_W-1:0] rd_buf,
    input  logic             from_idle,
    output logic [IDX_W-1:0] next_buf_c
);

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] i);
        return (32'(i) == N_BUF - 1) ? '0 : i + IDX_W'(1);
    endfunction

    logic [IDX_W-1:0] cand;

    always_comb begin
        cand = from_idle ? '0 : inc(cur_buf);
`ifdef FRAME_ADDR_GEN_SKIP_LOCKED_EN
        next_buf_c = (rd_lock && (cand == rd_buf)) ? inc(cand) : cand;
`else
        next_buf_c = cand;
`endif
    end

`ifndef FRAME_ADDR_GEN_SKIP_LOCKED_EN
    logic skip_unused;
    assign skip_unused = rd_lock ^ (^rd_buf);
`endif

endmodule

// File: rtl/frame_addr_gen.sv
// Burst address generator over N rotating frame buffers with a bounded queue of outstanding addresses.
// Optional feature: FRAME_ADDR_GEN_SKIP_LOCKED_EN (rotation skips the buffer held by the reader).
module frame_addr_gen
    import frame_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned N_BUF       = 4,
    parameter int unsigned BURST_BEATS = 16,
    parameter int unsigned BURST_BYTES = 128,
    parameter int unsigned MAX_PEND    = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [N_BUF*ADDR_W-1:0]   buf_base,
    input  logic [ADDR_W-1:0]         frame_bytes,
    input  logic                      frame_start,
    input  logic                      data_valid,
    input  logic                      rd_lock,
    input  logic [clog2(N_BUF)-1:0]   rd_buf,
    frame_addr_gen_if.master          aw,
    output logic [clog2(N_BUF)-1:0]   cur_buf,
    output logic                      frame_done,
    output logic [clog2(N_BUF)-1:0]   done_buf,
    output logic                      overrun
);

    localparam int unsigned IDX_W  = clog2(N_BUF);
    localparam int unsigned BEAT_W = (clog2(BURST_BEATS) > 0) ? clog2(BURST_BEATS) : 1;
    localparam int unsigned PEND_W = clog2(MAX_PEND + 1);
    localparam int unsigned XW     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(BURST_BYTES);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cur_buf_q, cur_buf_d;
    logic [IDX_W-1:0]  done_buf_q, done_buf_d;
    logic [ADDR_W-1:0] req_off_q, req_off_d;
    logic [ADDR_W-1:0] iss_off_q, iss_off_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              start_pend_q, start_pend_d;
    logic              overrun_q, overrun_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;

    logic [ADDR_W-1:0] base_a [N_BUF];
    logic [IDX_W-1:0]  next_buf;
    logic              hs, count_en, burst_start, room, frame_end, restart;

    for (genvar g = 0; g < N_BUF; g++) begin : g_base
        assign base_a[g] = buf_base[g*ADDR_W +: ADDR_W];
    end

    frame_addr_gen_buf_rotator #(
        .N_BUF (N_BUF),
        .IDX_W (IDX_W)
    ) u_rot (
        .cur_buf    (cur_buf_q),
        .rd_lock    (rd_lock),
        .rd_buf     (rd_buf),
        .from_idle  (state_q == IDLE),
        .next_buf_c (next_buf)
    );

    // Beat counting, queue bookkeeping and frame sequencing.
    always_comb begin
        state_d      = state_q;
        cur_buf_d    = cur_buf_q;
        done_buf_d   = done_buf_q;
        req_off_d    = req_off_q;
        iss_off_d    = iss_off_q;
        pend_d       = pend_q;
        beat_d       = beat_q;
        start_pend_d = start_pend_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        restart      = 1'b0;

        hs          = addr_valid_q && aw.addr_ready;
        count_en    = (state_q == RUN) && !start_pend_q && !frame_start && data_valid;
        burst_start = count_en && (beat_q == '0);
        room        = 32'(pend_q) < MAX_PEND;
        frame_end   = ({1'b0, req_off_q} + XW'(BURST_BYTES)) >= {1'b0, frame_bytes};

        if (count_en) begin
            beat_d = (32'(beat_q) == BURST_BEATS - 1) ? '0 : beat_q + BEAT_W'(1);
        end
        if (hs) iss_off_d = iss_off_q + INC;
        if (burst_start && room) req_off_d = req_off_q + INC;
        if (burst_start && !room) overrun_d = 1'b1;

        case ({burst_start && room, hs})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase

        if (((state_q == DRAIN) || (state_q == DONE)) && data_valid) overrun_d = 1'b1;
        if (((state_q == RUN) || (state_q == DRAIN)) && frame_start) start_pend_d = 1'b1;

        unique case (state_q)
            IDLE, DONE: begin
                if (frame_start) restart = 1'b1;
            end
            RUN: begin
                if (start_pend_q && (pend_q == '0)) restart = 1'b1;
                else if (burst_start && frame_end) state_d = DRAIN;
            end
            DRAIN: begin
                // An aborted frame drains silently and restarts without a done pulse.
                if (start_pend_q && (pend_q == '0)) begin
                    restart = 1'b1;
                end else if (!start_pend_q && !frame_start && (pend_d == '0)) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                    done_buf_d   = cur_buf_q;
                end
            end
        endcase

        if (restart) begin
            state_d      = RUN;
            cur_buf_d    = next_buf;
            req_off_d    = '0;
            iss_off_d    = '0;
            pend_d       = '0;
            beat_d       = '0;
            start_pend_d = 1'b0;
        end

        addr_d       = base_a[cur_buf_d] + iss_off_d;
        addr_valid_d = (pend_d != '0);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            cur_buf_q    <= '0;
            done_buf_q   <= '0;
            req_off_q    <= '0;
            iss_off_q    <= '0;
            pend_q       <= '0;
            beat_q       <= '0;
            start_pend_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_buf_q    <= cur_buf_d;
            done_buf_q   <= done_buf_d;
            req_off_q    <= req_off_d;
            iss_off_q    <= iss_off_d;
            pend_q       <= pend_d;
            beat_q       <= beat_d;
            start_pend_q <= start_pend_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign aw.addr       = addr_q;
    assign aw.addr_valid = addr_valid_q;
    assign cur_buf       = cur_buf_q;
    assign done_buf      = done_buf_q;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Directed bench for frame_addr_gen: N_BUF=3, 4-beat/64-byte bursts, two outstanding, 256-byte frames.
module tb_frame_addr_gen;
    import frame_addr_gen_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [95:0] buf_base;
    logic [31:0] frame_bytes;
    logic        frame_start, data_valid, rd_lock;
    logic [1:0]  rd_buf, cur_buf, done_buf;
    logic        frame_done, overrun;

    int total = 0;
    int bad   = 0;
    logic [31:0] got[$];
    int fd_cnt, fd_cyc, hs_cyc;
    int exp_b;
    logic [31:0] base_tab [3];

    frame_addr_gen_if #(.ADDR_W(32)) aw_if ();

    frame_addr_gen #(
        .ADDR_W(32), .N_BUF(3), .BURST_BEATS(4), .BURST_BYTES(64), .MAX_PEND(2)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .buf_base    (buf_base),
        .frame_bytes (frame_bytes),
        .frame_start (frame_start),
        .data_valid  (data_valid),
        .rd_lock     (rd_lock),
        .rd_buf      (rd_buf),
        .aw          (aw_if),
        .cur_buf     (cur_buf),
        .frame_done  (frame_done),
        .done_buf    (done_buf),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
    endtask

    // Drives beats for the first 'beats' cycles and logs handshakes / done pulses.
    task automatic run(input int cycles, input int beats);
        got.delete();
        fd_cnt = 0; fd_cyc = -1; hs_cyc = -1;
        for (int i = 0; i < cycles; i++) begin
            data_valid = (i < beats);
            if (aw_if.addr_valid && aw_if.addr_ready) begin
                got.push_back(aw_if.addr);
                hs_cyc = i;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = i;
            end
            tick();
        end
        data_valid = 1'b0;
    endtask

    function automatic logic [31:0] got_at(input int k);
        return (k < got.size()) ? got[k] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        sys_rst_n = 1'b0; frame_start = 1'b0; data_valid = 1'b0;
        rd_lock = 1'b0; rd_buf = 2'd0; aw_if.addr_ready = 1'b0;
        frame_bytes = 32'd256;
        buf_base = {32'h3000, 32'h2000, 32'h1000};
        base_tab[0] = 32'h1000; base_tab[1] = 32'h2000; base_tab[2] = 32'h3000;
        tick(); tick();

        chk("rst_addr_valid", 32'(aw_if.addr_valid), 0);
        chk("rst_addr", aw_if.addr, 0);
        chk("rst_cur_buf", 32'(cur_buf), 0);
        chk("rst_done_buf", 32'(done_buf), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        sys_rst_n = 1'b1;

        // Full frame with ready held high
        aw_if.addr_ready = 1'b1;
        pulse_start();
        chk("s1_state_run", 32'(dut.state_q), 32'(RUN));
        chk("s1_cur_buf", 32'(cur_buf), 0);
        run(20, 16);
        chk("s1_n_addr", 32'(got.size()), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("s1_addr%0d", k), got_at(k), 32'h1000 + 32'(k * 64));
        chk("s1_last_hs", 32'(hs_cyc), 13);
        chk("s1_fd_cyc", 32'(fd_cyc), 14);
        chk("s1_fd_cnt", 32'(fd_cnt), 1);
        chk("s1_done_buf", 32'(done_buf), 0);
        chk("s1_state_done", 32'(dut.state_q), 32'(DONE));
        chk("s1_tail_overrun", 32'(overrun), 1);

        // Skip of the reader's locked buffer while leaving DONE on buffer 0
        rd_lock = 1'b1; rd_buf = 2'd1;
        pulse_start();
`ifdef FRAME_ADDR_GEN_SKIP_LOCKED_EN
        exp_b = 2;
`else
        exp_b = 1;
`endif
        chk("skip_cur_buf", 32'(cur_buf), 32'(exp_b));
        rd_lock = 1'b0;
        run(20, 16);
        chk("skip_first_addr", got_at(0), base_tab[exp_b]);
        chk("skip_fd_cnt", 32'(fd_cnt), 1);
        chk("skip_done_buf", 32'(done_buf), 32'(exp_b));

        // Round-robin rotation over the remaining frames
        pulse_start();
        chk("rot_cur_buf_a", 32'(cur_buf), 32'((exp_b + 1) % 3));
        run(20, 16);
        chk("rot_first_addr_a", got_at(0), base_tab[(exp_b + 1) % 3]);
        chk("rot_done_buf_a", 32'(done_buf), 32'((exp_b + 1) % 3));
        pulse_start();
        chk("rot_cur_buf_b", 32'(cur_buf), 32'((exp_b + 2) % 3));

        // Backpressure: queue fills, third burst is dropped
        do_reset();
        aw_if.addr_ready = 1'b0;
        pulse_start();
        run(14, 12);
        chk("bp_valid_held", 32'(aw_if.addr_valid), 1);
        chk("bp_addr_held", aw_if.addr, 32'h1000);
        chk("bp_overrun", 32'(overrun), 1);
        chk("bp_no_hs", 32'(got.size()), 0);
        aw_if.addr_ready = 1'b1;
        run(8, 0);
        chk("bp_n_addr", 32'(got.size()), 2);
        chk("bp_addr0", got_at(0), 32'h1000);
        chk("bp_addr1", got_at(1), 32'h1040);
        chk("bp_valid_low", 32'(aw_if.addr_valid), 0);

        // Abort mid-frame: drain queued bursts, restart on the next buffer without a done pulse
        do_reset();
        aw_if.addr_ready = 1'b0;
        pulse_start();
        run(8, 6);
        pulse_start();
        aw_if.addr_ready = 1'b1;
        run(6, 0);
        chk("ab_n_addr", 32'(got.size()), 2);
        chk("ab_addr0", got_at(0), 32'h1000);
        chk("ab_addr1", got_at(1), 32'h1040);
        chk("ab_no_done", 32'(fd_cnt), 0);
        chk("ab_cur_buf", 32'(cur_buf), 1);
        chk("ab_state", 32'(dut.state_q), 32'(RUN));
        run(4, 1);
        chk("ab_restart_addr", got_at(0), 32'h2000);
        chk("ab_restart_n", 32'(got.size()), 1);
        chk("ab_no_done2", 32'(fd_cnt), 0);

        // Reset mid-frame discards everything
        do_reset();
        aw_if.addr_ready = 1'b0;
        pulse_start();
        run(10, 10);
        chk("mr_pre_overrun", 32'(overrun), 1);
        chk("mr_pre_cur_buf", 32'(cur_buf), 0);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        chk("mr_addr_valid", 32'(aw_if.addr_valid), 0);
        chk("mr_cur_buf", 32'(cur_buf), 0);
        chk("mr_overrun", 32'(overrun), 0);
        chk("mr_state", 32'(dut.state_q), 32'(IDLE));
        aw_if.addr_ready = 1'b1;
        run(8, 8);
        chk("mr_idle_no_addr", 32'(got.size()), 0);
        chk("mr_idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("mr_idle_overrun", 32'(overrun), 0);
        pulse_start();
        chk("mr_restart_state", 32'(dut.state_q), 32'(RUN));
        run(4, 1);
        chk("mr_restart_addr", got_at(0), 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
